mult_seq: RTL



---
 rtl/mult_seq_if.sv | 21 ++
 rtl/mult_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/mult_seq_if.sv
// Operand/opcode bus between the multiplier sequencer and an external alu32.
// The sequencer drives a/b/op; the ALU answers combinationally in the same cycle.
interface mult_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  modport master (
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_zero
  );

  modport slave (
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_zero
  );
endinterface

// File: rtl/mult_seq.sv
// Shift-add unsigned multiplier (low WIDTH bits) that borrows an external alu32
// for the bit test (AND) and accumulation (ADD); this block only sequences and shifts.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [2:0]       dbg_state,
  mult_seq_if.master       alu
);

  // Request handshake: start is sampled only in IDLE and is otherwise dropped
  // (no queuing); operands are captured on that accepting edge. busy is high
  // while working, done pulses for one cycle with product already valid.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier, acc;
  logic             mplier_last;

  // True when the multiplier has no set bits left after this shift.
  assign mplier_last = (mplier[WIDTH-1:1] == '0);
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (op_b == '0) ? S_DONE : S_CHECK;
      S_CHECK: state_nxt = alu.alu_zero ? S_SHIFT : S_ADD;
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = mplier_last ? S_DONE : S_CHECK;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    alu.alu_a  = '0;
    alu.alu_b  = '0;
    alu.alu_op = OP_AND;
    case (state)
      S_CHECK: begin
        busy       = 1'b1;
        alu.alu_a  = mplier;
        alu.alu_b  = WIDTH'(1);
        alu.alu_op = OP_AND;
      end
      S_ADD: begin
        busy       = 1'b1;
        alu.alu_a  = acc;
        alu.alu_b  = mcand;
        alu.alu_op = OP_ADD;
      end
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers; product only changes on an edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mcand  <= op_a;
          mplier <= op_b;
          acc    <= '0;
          if (op_b == '0) product <= '0;
        end
        S_ADD: acc <= alu.alu_result;
        S_SHIFT: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (mplier_last) product <= acc;
        end
        default: ;
      endcase
    end
  end

endmodule
